data_mem_responder: RTL and testbench

//  Data-memory side of the pipeline's stage-4 memory interface. Accepts one load/store

---
 rtl/proc_mem_pkg.sv | 12 +
 rtl/dmem_array.sv | 20 ++
 rtl/data_mem_responder.sv | 74 +++++++
 tb/tb_data_mem_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_mem_pkg.sv
// proc_mem_pkg: shared FSM encoding and word/lane geometry for the data-memory responder
package proc_mem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
  localparam int LANE_W = 8;
  localparam int LANES = 4;
  localparam int WORD_W = LANE_W * LANES;
  localparam int DEF_WAIT_STATES = 2;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM with synchronous read and per-byte write enables
module dmem_array
  import proc_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic [LANES-1:0]  we,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (we[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: one-outstanding load/store responder with wait states in front of the data RAM
module data_mem_responder
  import proc_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = DEF_WAIT_STATES,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [LANES-1:0] req_be,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             addr_err,
  output logic             stall
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic write_q;
  logic [31:0] addr_q, wdata_q, ram_rdata;
  logic [LANES-1:0] be_q, ram_we;
  logic [AW-1:0] ram_addr;
  logic [32:0] off_q;
  logic accept, err;
  assign accept = state == IDLE && req_valid;
  // 33-bit offset: a borrow below BASE_ADDR lands above SPAN, so one compare covers both bounds
  assign off_q = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign err = |addr_q[1:0] || off_q >= SPAN;
  // IDLE reads from the incoming address so a zero-wait load has data by RESP
  assign ram_addr = AW'(((state == IDLE ? req_addr : addr_q) - BASE_ADDR) >> 2);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
    if (accept) begin
      write_q <= req_write;
      addr_q <= req_addr;
      wdata_q <= req_wdata;
      be_q <= req_be;
    end
  end
  always_comb begin
    state_n = accept ? (WAIT_STATES > 0 ? WAIT : RESP) :
              state == WAIT ? (cnt == CW'(1) ? RESP : WAIT) : IDLE;
    cnt_n = accept ? CW'(WAIT_STATES) : state == WAIT ? cnt - CW'(1) : cnt;
  end
  always_comb begin
    req_ready = !reset && state == IDLE;
    stall = !reset && (accept || state == WAIT);
    rsp_valid = !reset && state == RESP;
    addr_err = rsp_valid && err;
    rsp_rdata = rsp_valid && !write_q && !err ? ram_rdata : '0;
    ram_we = rsp_valid && write_q && !err ? be_q : '0;
  end
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk(clk),
    .addr(ram_addr),
    .we(ram_we),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized checks of two responders (2 and 0 wait states) against a word-map model
module tb_data_mem_responder;
  localparam int WS_A = 2;
  localparam int DEPTH = 1024;
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  logic clk = 1'b0, reset = 1'b1;
  logic a_valid = 1'b0, a_write = 1'b0, b_valid = 1'b0, b_write = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic [3:0] a_be = '0, b_be = '0;
  logic a_ready, a_rsp, a_err, a_stall, b_ready, b_rsp, b_err, b_stall;
  logic [31:0] a_rdata, b_rdata;
  int tests = 0, fails = 0;
  logic [31:0] ref_mem [int];
  logic [3:0] ref_known [int];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A), .BASE_ADDR(32'h0)) u_a (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_write(a_write), .req_addr(a_addr),
    .req_wdata(a_wdata), .req_be(a_be), .req_ready(a_ready), .rsp_valid(a_rsp),
    .rsp_rdata(a_rdata), .addr_err(a_err), .stall(a_stall));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_b (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_write(b_write), .req_addr(b_addr),
    .req_wdata(b_wdata), .req_be(b_be), .req_ready(b_ready), .rsp_valid(b_rsp),
    .rsp_rdata(b_rdata), .addr_err(b_err), .stall(b_stall));

  task automatic a_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] got);
    logic exp_err, chk_rd;
    logic [31:0] exp_rd, m;
    int k, word;
    exp_err = a[1:0] != 2'b00 || a >= SPAN;
    word = int'(a >> 2);
    chk_rd = 1'b1;
    exp_rd = '0;
    if (!w && !exp_err) begin
      if (ref_known.exists(word) && ref_known[word] == 4'hF) exp_rd = ref_mem[word];
      else chk_rd = 1'b0;
    end
    @(negedge clk);
    a_valid = 1'b1; a_write = w; a_addr = a; a_wdata = d; a_be = be;
    #1 tests++;
    if ({a_ready, a_stall, a_rsp} !== 3'b110) begin
      fails++; $display("FAIL accept addr=%h: ready/stall/rsp=%b required 110", a, {a_ready, a_stall, a_rsp});
    end
    @(negedge clk);
    a_valid = 1'b0; a_write = 1'($urandom); a_addr = $urandom; a_wdata = $urandom; a_be = 4'($urandom);
    #1 k = 1;
    while (a_rsp !== 1'b1 && k < 12) begin
      tests++;
      if (a_stall !== 1'b1) begin
        fails++; $display("FAIL wait_stall addr=%h cycle %0d: stall=%b required 1", a, k, a_stall);
      end
      @(negedge clk);
      #1 k++;
    end
    tests++;
    if (k != WS_A + 1) begin
      fails++; $display("FAIL latency addr=%h: response in cycle %0d required %0d", a, k, WS_A + 1);
    end
    tests++;
    if ({a_rsp, a_stall, a_ready} !== 3'b100) begin
      fails++; $display("FAIL resp_flags addr=%h: rsp/stall/ready=%b required 100", a, {a_rsp, a_stall, a_ready});
    end
    tests++;
    if (a_err !== exp_err) begin
      fails++; $display("FAIL addr_err addr=%h: got %b required %b", a, a_err, exp_err);
    end
    if (chk_rd) begin
      tests++;
      if (a_rdata !== exp_rd) begin
        fails++; $display("FAIL rdata addr=%h write=%b: got %h required %h", a, w, a_rdata, exp_rd);
      end
    end
    got = a_rdata;
    if (w && !exp_err && be != 4'h0) begin
      m = ref_mem.exists(word) ? ref_mem[word] : 32'h0;
      if (!ref_known.exists(word)) ref_known[word] = 4'h0;
      for (int i = 0; i < 4; i++)
        if (be[i]) m[i*8 +: 8] = d[i*8 +: 8];
      ref_mem[word] = m;
      ref_known[word] = ref_known[word] | be;
    end
    @(negedge clk);
    #1 tests++;
    if ({a_rsp, a_ready, a_err} !== 3'b010 || a_rdata !== 32'h0) begin
      fails++; $display("FAIL rsp_pulse addr=%h: rsp/ready/err=%b rdata=%h required 010 and 0", a, {a_rsp, a_ready, a_err}, a_rdata);
    end
  endtask

  task automatic b_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] exp_rd);
    @(negedge clk);
    b_valid = 1'b1; b_write = w; b_addr = a; b_wdata = d; b_be = be;
    #1 tests++;
    if ({b_ready, b_stall, b_rsp} !== 3'b110) begin
      fails++; $display("FAIL b_accept addr=%h: ready/stall/rsp=%b required 110", a, {b_ready, b_stall, b_rsp});
    end
    @(negedge clk);
    #1 tests++;
    if ({b_rsp, b_ready, b_stall, b_err} !== 4'b1000) begin
      fails++; $display("FAIL b_resp addr=%h: rsp/ready/stall/err=%b required 1000", a, {b_rsp, b_ready, b_stall, b_err});
    end
    tests++;
    if (b_rdata !== exp_rd) begin
      fails++; $display("FAIL b_rdata addr=%h: got %h required %h", a, b_rdata, exp_rd);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 tests++;
    if ({a_ready, a_rsp, a_err, a_stall} !== 4'b0 || a_rdata !== 32'h0) begin
      fails++; $display("FAIL reset_a: ready/rsp/err/stall=%b rdata=%h required all 0", {a_ready, a_rsp, a_err, a_stall}, a_rdata);
    end
    tests++;
    if ({b_ready, b_rsp, b_err, b_stall} !== 4'b0 || b_rdata !== 32'h0) begin
      fails++; $display("FAIL reset_b: ready/rsp/err/stall=%b rdata=%h required all 0", {b_ready, b_rsp, b_err, b_stall}, b_rdata);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1 tests++;
    if ({a_ready, a_stall, b_ready, b_stall} !== 4'b1010) begin
      fails++; $display("FAIL post_reset_idle: a/b ready,stall=%b required 1010", {a_ready, a_stall, b_ready, b_stall});
    end
  endtask

  task automatic test_store_load();
    logic [31:0] got;
    a_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, got);
    a_req(1'b0, 32'h10, 32'h0, 4'h0, got);
    tests++;
    if (got !== 32'hDEADBEEF) begin
      fails++; $display("FAIL store_load: got %h required deadbeef", got);
    end
  endtask

  task automatic test_partial();
    logic [31:0] got;
    a_req(1'b1, 32'h10, 32'h000000AA, 4'b0001, got);
    a_req(1'b1, 32'h10, 32'h55555555, 4'b0000, got);
    a_req(1'b0, 32'h10, 32'h0, 4'h0, got);
    tests++;
    if (got !== 32'hDEADBEAA) begin
      fails++; $display("FAIL partial_store: got %h required deadbeaa", got);
    end
  endtask

  task automatic test_errors();
    logic [31:0] got;
    a_req(1'b1, 32'h0, 32'h0BADF00D, 4'hF, got);
    a_req(1'b1, SPAN - 32'h4, 32'h5A5A1234, 4'hF, got);
    a_req(1'b0, 32'h12, 32'h0, 4'h0, got);
    a_req(1'b1, SPAN, 32'hFFFFFFFF, 4'hF, got);
    a_req(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, got);
    a_req(1'b0, 32'h0, 32'h0, 4'h0, got);
    a_req(1'b0, SPAN - 32'h4, 32'h0, 4'h0, got);
    tests++;
    if (got !== 32'h5A5A1234) begin
      fails++; $display("FAIL last_word_kept: got %h required 5a5a1234", got);
    end
  endtask

  task automatic test_back_to_back();
    b_req(1'b1, 32'h0, 32'h11111111, 4'hF, 32'h0);
    b_req(1'b1, 32'h4, 32'h22222222, 4'hF, 32'h0);
    b_req(1'b0, 32'h0, 32'h0, 4'h0, 32'h11111111);
    b_req(1'b0, 32'h4, 32'h0, 4'h0, 32'h22222222);
    b_req(1'b0, 32'h0, 32'h0, 4'h0, 32'h11111111);
    @(negedge clk);
    b_valid = 1'b0;
    #1 tests++;
    if ({b_ready, b_rsp, b_stall} !== 3'b100) begin
      fails++; $display("FAIL b_idle: ready/rsp/stall=%b required 100", {b_ready, b_rsp, b_stall});
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    logic seen;
    a_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, got);
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h20; a_wdata = 32'h12345678; a_be = 4'hF;
    @(negedge clk);
    a_valid = 1'b0; reset = 1'b1;
    for (int n = 0; n < 2; n++) begin
      #1 tests++;
      if ({a_ready, a_rsp, a_err, a_stall} !== 4'b0 || a_rdata !== 32'h0) begin
        fails++; $display("FAIL mid_reset_outputs step %0d: ready/rsp/err/stall=%b rdata=%h required all 0", n, {a_ready, a_rsp, a_err, a_stall}, a_rdata);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      #1 if (a_rsp === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (seen) begin
      fails++; $display("FAIL dropped_rsp: rsp_valid=1 seen after reset required 0");
    end
    a_req(1'b0, 32'h20, 32'h0, 4'h0, got);
    tests++;
    if (got !== 32'hCAFEF00D) begin
      fails++; $display("FAIL pre_reset_contents: got %h required cafef00d", got);
    end
  endtask

  task automatic test_random();
    logic [31:0] got, a;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        8: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        9: a = $urandom_range(0, 1) == 0 ? SPAN + 32'($urandom_range(0, 255) * 4) : 32'hFFFFFFFC;
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      a_req(1'($urandom), a, $urandom, 4'($urandom), got);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_load();
    test_partial();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
